// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0]  DEFAULT_MAGIC  = 8'hA5;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control status.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream; word_valid fires
// combinationally with the 4th byte so the caller can register the write.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [23:0]       sr_q, sr_d;

  always_comb begin
    idx_d      = idx_q;
    sr_d       = sr_q;
    word_valid = 1'b0;
    word       = {sr_q, byte_in};
    if (clear) begin
      idx_d = '0;
      sr_d  = '0;
    end else if (byte_valid) begin
      sr_d       = {sr_q[15:0], byte_in};
      idx_d      = idx_q + 1'b1;
      word_valid = (idx_q == BIDX_W'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Parses framed byte stream (magic, 16-bit count, words, XOR checksum) and
// writes instruction memory; holds the core in reset until a frame loads cleanly.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = DEFAULT_MAGIC
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       widx_q, widx_d;
  logic [7:0]        csum_q, csum_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        accept;
  logic        is_magic;
  logic        frame_start;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign accept      = bus.in_valid && in_ready_q;
  assign is_magic    = (bus.in_data == MAGIC);
  assign frame_start = accept && is_magic &&
                       (state_q == IDLE || state_q == DONE || state_q == ERR);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (frame_start),
    .byte_valid (accept && (state_q == DATA)),
    .byte_in    (bus.in_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_d    = state_q;
    in_ready_d = 1'b1;
    cnt_hi_d   = cnt_hi_q;
    count_d    = count_q;
    widx_d     = widx_q;
    csum_d     = csum_q;
    imem_we_d  = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (frame_start) begin
          state_d = CNT_HI;
          csum_d  = '0;
        end
      end
      CNT_HI: begin
        if (accept) begin
          cnt_hi_d = bus.in_data;
          state_d  = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          count_d = {cnt_hi_q, bus.in_data};
          widx_d  = '0;
          if ({1'b0, cnt_hi_q, bus.in_data} > CAP) state_d = ERR;
          else if ({cnt_hi_q, bus.in_data} == 16'd0) state_d = CSUM;
          else state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ bus.in_data;
          // Leave DATA on the last word's final byte so a checksum byte
          // arriving on the very next cycle is still consumed.
          if (pk_valid) begin
            imem_we_d = 1'b1;
            addr_d    = widx_q[ADDR_W-1:0];
            wdata_d   = pk_word;
            widx_d    = widx_q + 16'd1;
            if (widx_q == count_q - 16'd1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) state_d = (bus.in_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase

    hold_d = (state_d != DONE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      cnt_hi_q   <= '0;
      count_q    <= '0;
      widx_q     <= '0;
      csum_q     <= '0;
      imem_we_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cnt_hi_q   <= cnt_hi_d;
      count_q    <= count_d;
      widx_q     <= widx_d;
      csum_q     <= csum_d;
      imem_we_q  <= imem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus hand-written corner cases,
// with a write scoreboard checked on every cycle.
module tb_imem_loader;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct packed {
    logic [7:0]   len;
    logic [159:0] b;     // first byte in [159:152]
    logic [1:0]   nwr;
    logic [95:0]  wd;    // word k in [95-32k -: 32], written to address k
    logic         gaps;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.imem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got we=%b addr %h data %h expected no write",
                 bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("wr_data", bus.imem_wdata, e.data);
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic gap();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    tick();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, 32'(bus.done), 32'(d));
    check({tag, "_err"}, 32'(bus.err), 32'(e));
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        v;
    logic [7:0]  cs;
    logic [7:0]  k8;
    logic [31:0] w;

    vecs[0] = '{len: 8'd8, b: {64'hA5_0001_DEADBEEF_22, 96'h0}, nwr: 2'd1,
                wd: {32'hDEADBEEF, 64'h0}, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{len: 8'd16, b: {128'hA50003_00010203_04050607_08090A0B_00, 32'h0}, nwr: 2'd3,
                wd: {32'h00010203, 32'h04050607, 32'h08090A0B}, gaps: 1'b1,
                exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{len: 8'd8, b: {64'hA5_0001_11223344_FF, 96'h0}, nwr: 2'd1,
                wd: {32'h11223344, 64'h0}, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{len: 8'd8, b: {64'hA5_0001_CAFEBABE_30, 96'h0}, nwr: 2'd1,
                wd: {32'hCAFEBABE, 64'h0}, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{len: 8'd3, b: {24'hA50101, 136'h0}, nwr: 2'd0,
                wd: 96'h0, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{len: 8'd4, b: {32'hA5000000, 128'h0}, nwr: 2'd0,
                wd: 96'h0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    tick();
    check("por_in_ready_rise", 32'(bus.in_ready), 32'd1);

    // Junk before MAGIC, including a gap carrying the magic value with in_valid low.
    send(8'h00);
    send(8'hFF);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hA5;
    tick();
    send(8'h12);
    send(8'h00);
    send(8'h01);
    check_status("junk", 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      for (int k = 0; k < int'(v.nwr); k++)
        exp_q.push_back('{addr: AW'(k), data: v.wd[95-32*k -: 32]});
      for (int j = 0; j < int'(v.len); j++) begin
        send(v.b[159-8*j -: 8]);
        if (v.gaps && (j % 3 == 1)) begin
          gap();
          gap();
        end
      end
      gap();
      gap();
      check_status($sformatf("vec%0d", i), v.exp_done, v.exp_err, !v.exp_done);
    end

    // Restart from DONE: hold and done change right after MAGIC is taken.
    send(8'hA5);
    check("restart_hold", 32'(bus.cpu_hold), 32'd1);
    check("restart_done", 32'(bus.done), 32'd0);
    exp_q.push_back('{addr: AW'(0), data: 32'h01020304});
    send(8'h00);
    send(8'h01);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'h04);
    check_status("reload", 1'b1, 1'b0, 1'b0);

    // Reset halfway through a word: nothing written, outputs back to reset values.
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    send(8'hCC);
    send(8'hDD);
    check_status("midrst_idle", 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{addr: AW'(0), data: 32'h10203040});
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h10);
    send(8'h20);
    send(8'h30);
    send(8'h40);
    send(8'h40);
    check_status("post_rst", 1'b1, 1'b0, 1'b0);

    // Full capacity: 256 words, last address 255, no wrap before checksum.
    cs = 8'h00;
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      w  = {k8, k8 ^ 8'h5A, ~k8, k8 + 8'd3};
      exp_q.push_back('{addr: AW'(k), data: w});
      for (int j = 0; j < 4; j++) begin
        cs = cs ^ w[31-8*j -: 8];
        send(w[31-8*j -: 8]);
      end
    end
    send(cs);
    gap();
    check_status("full", 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
